// File: rtl/alu_pkg.sv
// Shared ALUOp encoding and MIPS64 opcode/funct constants for the EX-stage ALU issue path.
package alu_pkg;

    typedef logic [3:0] aluop_t;

    localparam aluop_t ALU_NONE = 4'd0;
    localparam aluop_t ALU_AND  = 4'd1;
    localparam aluop_t ALU_OR   = 4'd2;
    localparam aluop_t ALU_ADD  = 4'd3;
    localparam aluop_t ALU_SUB  = 4'd4;
    localparam aluop_t ALU_EQ   = 4'd5;
    localparam aluop_t ALU_MULT = 4'd6;
    localparam aluop_t ALU_NOR  = 4'd7;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_DADDI = 6'h18;

    localparam logic [5:0] FN_DMULT = 6'h1C;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_DADD  = 6'h2C;
    localparam logic [5:0] FN_DSUB  = 6'h2E;

    // Only the add/subtract class drives a meaningful overflow/carry out of the ALU.
    function automatic logic op_has_ovf(input aluop_t op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational opcode/funct/imm decode into ALUOp, operand-b source select and illegal flag.
module alu_decode
    import alu_pkg::*;
#(
    parameter int SIZE = 64
) (
    input  logic [5:0]      opcode,
    input  logic [5:0]      funct,
    input  logic [15:0]     imm,
    output aluop_t          alu_op,
    output logic            use_imm,
    output logic [SIZE-1:0] imm_ext,
    output logic            illegal
);

    always_comb begin
        alu_op  = ALU_NONE;
        use_imm = 1'b0;
        imm_ext = {{(SIZE-16){1'b0}}, imm};
        illegal = 1'b0;
        case (opcode)
            OPC_RTYPE: begin
                case (funct)
                    FN_AND:   alu_op = ALU_AND;
                    FN_OR:    alu_op = ALU_OR;
                    FN_DADD:  alu_op = ALU_ADD;
                    FN_DSUB:  alu_op = ALU_SUB;
                    FN_NOR:   alu_op = ALU_NOR;
                    FN_DMULT: alu_op = ALU_MULT;
                    default:  illegal = 1'b1;
                endcase
            end
            OPC_DADDI: begin
                alu_op  = ALU_ADD;
                use_imm = 1'b1;
                imm_ext = {{(SIZE-16){imm[15]}}, imm};
            end
            OPC_ANDI: begin
                alu_op  = ALU_AND;
                use_imm = 1'b1;
            end
            OPC_ORI: begin
                alu_op  = ALU_OR;
                use_imm = 1'b1;
            end
            OPC_BEQ:  alu_op = ALU_EQ;
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// EX-stage ALU initiator: decode + issue register driving an external ALU, then a result register toward MEM.
// Optional build macro ALU_MULTICYCLE_MULT_EN holds MULT ops in the issue stage for MULT_LAT cycles.
module alu_issue
    import alu_pkg::*;
#(
    parameter int SIZE     = 64,
    parameter int MULT_LAT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [5:0]      opcode,
    input  logic [5:0]      funct,
    input  logic [SIZE-1:0] rs_val,
    input  logic [SIZE-1:0] rt_val,
    input  logic [15:0]     imm,
    output logic [3:0]      alu_op,
    output logic [SIZE-1:0] alu_a,
    output logic [SIZE-1:0] alu_b,
    input  logic [SIZE-1:0] alu_out,
    input  logic            alu_zero,
    input  logic            alu_overflow,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [SIZE-1:0] res_data,
    output logic            res_zero,
    output logic            res_ovf,
    output logic            res_illegal
);

    aluop_t          dec_op;
    logic            dec_use_imm;
    logic [SIZE-1:0] dec_imm_ext;
    logic            dec_illegal;

    alu_decode #(.SIZE(SIZE)) u_decode (
        .opcode  (opcode),
        .funct   (funct),
        .imm     (imm),
        .alu_op  (dec_op),
        .use_imm (dec_use_imm),
        .imm_ext (dec_imm_ext),
        .illegal (dec_illegal)
    );

    logic            vld_p1_q, vld_p1_d;
    aluop_t          op_p1_q, op_p1_d;
    logic [SIZE-1:0] a_p1_q, a_p1_d;
    logic [SIZE-1:0] b_p1_q, b_p1_d;
    logic            ill_p1_q, ill_p1_d;

    logic            vld_p2_q, vld_p2_d;
    logic [SIZE-1:0] data_p2_q, data_p2_d;
    logic            zero_p2_q, zero_p2_d;
    logic            ovf_p2_q, ovf_p2_d;
    logic            ill_p2_q, ill_p2_d;

    logic accept;
    logic s1_done;
    logic s1_adv;

    assign s1_adv   = vld_p1_q && s1_done && (!vld_p2_q || res_ready);
    assign in_ready = !vld_p1_q || s1_adv;
    assign accept   = in_valid && in_ready;

`ifdef ALU_MULTICYCLE_MULT_EN
    localparam int CNT_W = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
    localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(MULT_LAT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter only reloads on accept, which cannot happen while a MULT is still holding stage 1.
    always_comb begin
        cnt_d = cnt_q;
        if (accept && (dec_op == ALU_MULT)) begin
            cnt_d = HOLD_INIT;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign s1_done = (cnt_q == '0);
`else
    // Always true; MULT_LAT only shapes the multicycle build.
    assign s1_done = (MULT_LAT >= 0);
`endif

    always_comb begin
        // Stage 1: issue register
        vld_p1_d = vld_p1_q;
        op_p1_d  = op_p1_q;
        a_p1_d   = a_p1_q;
        b_p1_d   = b_p1_q;
        ill_p1_d = ill_p1_q;
        if (accept) begin
            vld_p1_d = 1'b1;
            op_p1_d  = dec_op;
            a_p1_d   = rs_val;
            b_p1_d   = dec_use_imm ? dec_imm_ext : rt_val;
            ill_p1_d = dec_illegal;
        end else if (s1_adv) begin
            vld_p1_d = 1'b0;
        end

        // Stage 2: result register
        vld_p2_d  = vld_p2_q;
        data_p2_d = data_p2_q;
        zero_p2_d = zero_p2_q;
        ovf_p2_d  = ovf_p2_q;
        ill_p2_d  = ill_p2_q;
        if (s1_adv) begin
            vld_p2_d  = 1'b1;
            data_p2_d = ill_p1_q ? '0 : alu_out;
            zero_p2_d = alu_zero;
            ovf_p2_d  = alu_overflow && op_has_ovf(op_p1_q);
            ill_p2_d  = ill_p1_q;
        end else if (res_ready) begin
            vld_p2_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1_q  <= 1'b0;
            op_p1_q   <= ALU_NONE;
            a_p1_q    <= '0;
            b_p1_q    <= '0;
            ill_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            data_p2_q <= '0;
            zero_p2_q <= 1'b0;
            ovf_p2_q  <= 1'b0;
            ill_p2_q  <= 1'b0;
        end else begin
            vld_p1_q  <= vld_p1_d;
            op_p1_q   <= op_p1_d;
            a_p1_q    <= a_p1_d;
            b_p1_q    <= b_p1_d;
            ill_p1_q  <= ill_p1_d;
            vld_p2_q  <= vld_p2_d;
            data_p2_q <= data_p2_d;
            zero_p2_q <= zero_p2_d;
            ovf_p2_q  <= ovf_p2_d;
            ill_p2_q  <= ill_p2_d;
        end
    end

    assign alu_op      = op_p1_q;
    assign alu_a       = a_p1_q;
    assign alu_b       = b_p1_q;
    assign res_valid   = vld_p2_q;
    assign res_data    = data_p2_q;
    assign res_zero    = zero_p2_q;
    assign res_ovf     = ovf_p2_q;
    assign res_illegal = ill_p2_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural ALU hung off the issue-stage outputs.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [63:0] rs_val;
    logic [63:0] rt_val;
    logic [15:0] imm;
    logic [3:0]  alu_op;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [63:0] alu_out;
    logic        alu_zero;
    logic        alu_overflow;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] res_data;
    logic        res_zero;
    logic        res_ovf;
    logic        res_illegal;

    int total = 0;
    int bad   = 0;

`ifdef ALU_MULTICYCLE_MULT_EN
    localparam int MULT_N = 5;
`else
    localparam int MULT_N = 2;
`endif

    always #5 clk = ~clk;

    alu_issue #(.SIZE(64), .MULT_LAT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .opcode       (opcode),
        .funct        (funct),
        .rs_val       (rs_val),
        .rt_val       (rt_val),
        .imm          (imm),
        .alu_op       (alu_op),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_out      (alu_out),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_zero     (res_zero),
        .res_ovf      (res_ovf),
        .res_illegal  (res_illegal)
    );

    // External ALU: overflow is left high for non-arith ops to mimic a stale flag.
    logic [64:0] sum;
    always_comb begin
        sum          = '0;
        alu_out      = '0;
        alu_overflow = 1'b1;
        case (alu_op)
            4'd1: alu_out = alu_a & alu_b;
            4'd2: alu_out = alu_a | alu_b;
            4'd3: begin
                sum          = {1'b0, alu_a} + {1'b0, alu_b};
                alu_out      = sum[63:0];
                alu_overflow = sum[64];
            end
            4'd4: begin
                alu_out      = alu_a - alu_b;
                alu_overflow = (alu_a < alu_b);
            end
            4'd5: alu_out = {63'd0, (alu_a == alu_b)};
            4'd6: alu_out = alu_a * alu_b;
            4'd7: alu_out = ~(alu_a | alu_b);
            default: alu_out = alu_a ^ alu_b;
        endcase
        alu_zero = (alu_out == 64'd0);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [5:0] opc, input logic [5:0] fn, input logic [63:0] rs,
                         input logic [63:0] rt, input logic [15:0] im);
        in_valid = 1'b1;
        opcode   = opc;
        funct    = fn;
        rs_val   = rs;
        rt_val   = rt;
        imm      = im;
    endtask

    // One op through an idle pipe with res_ready high: result visible two edges after acceptance.
    task automatic issue1(input string tag, input logic [5:0] opc, input logic [5:0] fn,
                          input logic [63:0] rs, input logic [63:0] rt, input logic [15:0] im,
                          input logic [3:0] e_op, input logic [63:0] e_b, input logic [63:0] e_data,
                          input logic e_zero, input logic e_ovf, input logic e_ill);
        @(posedge clk); #1;
        drive(opc, fn, rs, rt, im);
        @(negedge clk);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_alu_op"}, 64'(alu_op), 64'(e_op));
        chk({tag, "_alu_a"}, alu_a, rs);
        chk({tag, "_alu_b"}, alu_b, e_b);
        chk({tag, "_early_valid"}, 64'(res_valid), 64'd0);
        @(negedge clk);
        chk({tag, "_res_valid"}, 64'(res_valid), 64'd1);
        chk({tag, "_res_data"}, res_data, e_data);
        chk({tag, "_res_zero"}, 64'(res_zero), 64'(e_zero));
        chk({tag, "_res_ovf"}, 64'(res_ovf), 64'(e_ovf));
        chk({tag, "_res_ill"}, 64'(res_illegal), 64'(e_ill));
    endtask

    logic [63:0] got_q[$];
    int          got_n;
    bit          saw_stall;
    bit          unstable;
    bit          prod_timeout;
    int          lat;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        opcode    = '0;
        funct     = '0;
        rs_val    = '0;
        rt_val    = '0;
        imm       = '0;
        res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_alu_op", 64'(alu_op), 64'd0);
        chk("rst_alu_a", alu_a, 64'd0);
        chk("rst_alu_b", alu_b, 64'd0);
        chk("rst_res_data", res_data, 64'd0);

        issue1("dadd", 6'h00, 6'h2C, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 16'h0,
               4'd3, 64'd1, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0);
        issue1("andi", 6'h0C, 6'h00, 64'hFFFF_FFFF_FFFF_F0F0, 64'd0, 16'h8F0F,
               4'd1, 64'h8F0F, 64'h8000, 1'b0, 1'b0, 1'b0);
        issue1("daddi", 6'h18, 6'h00, 64'd5, 64'd0, 16'hFFFF,
               4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd4, 1'b0, 1'b1, 1'b0);
        issue1("beq", 6'h04, 6'h00, 64'h1234, 64'h1234, 16'h0,
               4'd5, 64'h1234, 64'd1, 1'b0, 1'b0, 1'b0);
        issue1("dsub", 6'h00, 6'h2E, 64'h1234, 64'h1234, 16'h0,
               4'd4, 64'h1234, 64'd0, 1'b1, 1'b0, 1'b0);
        issue1("ori", 6'h0D, 6'h00, 64'hF000, 64'd0, 16'h00FF,
               4'd2, 64'h00FF, 64'hF0FF, 1'b0, 1'b0, 1'b0);
        issue1("nor", 6'h00, 6'h27, 64'd0, 64'd0, 16'h0,
               4'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
        issue1("and", 6'h00, 6'h24, 64'hFF00, 64'h0FF0, 16'h0,
               4'd1, 64'h0FF0, 64'h0F00, 1'b0, 1'b0, 1'b0);
        issue1("ill_opc", 6'h3F, 6'h00, 64'd5, 64'd7, 16'h0,
               4'd0, 64'd7, 64'd0, 1'b0, 1'b0, 1'b1);
        issue1("after_ill", 6'h0D, 6'h00, 64'h100, 64'd0, 16'h0001,
               4'd2, 64'h1, 64'h101, 1'b0, 1'b0, 1'b0);
        issue1("ill_fn", 6'h00, 6'h3F, 64'd1, 64'd3, 16'h0,
               4'd0, 64'd3, 64'd0, 1'b0, 1'b0, 1'b1);

        // DMULT 3x5, latency depends on the multicycle build option
        @(posedge clk); #1;
        drive(6'h00, 6'h1C, 64'd3, 64'd5, 16'h0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(negedge clk);
            if (res_valid) lat = c;
        end
        chk("mult_latency", 64'(lat), 64'(MULT_N));
        chk("mult_data", res_data, 64'd15);

        // Stream of four ORIs with a three-cycle result stall after the first delivery
        @(posedge clk); #1;
        got_q.delete();
        got_n        = 0;
        saw_stall    = 1'b0;
        unstable     = 1'b0;
        prod_timeout = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    bit acc;
                    drive(6'h0D, 6'h00, 64'((i + 1) * 16), 64'd0, 16'h0001);
                    acc = 1'b0;
                    for (int w = 0; w < 40 && !acc; w++) begin
                        @(negedge clk);
                        acc = in_ready;
                        @(posedge clk); #1;
                    end
                    if (!acc) prod_timeout = 1'b1;
                end
                in_valid = 1'b0;
            end
            begin
                int          hold;
                bit          first;
                bit          have_sv;
                logic [63:0] sv;
                hold    = 0;
                first   = 1'b0;
                have_sv = 1'b0;
                sv      = '0;
                for (int c = 0; c < 60 && got_n < 4; c++) begin
                    @(negedge clk);
                    if (res_valid && !res_ready) begin
                        if (!in_ready) saw_stall = 1'b1;
                        if (have_sv && res_data != sv) unstable = 1'b1;
                        sv      = res_data;
                        have_sv = 1'b1;
                    end
                    if (res_valid && res_ready) begin
                        got_q.push_back(res_data);
                        got_n++;
                        if (!first) begin
                            first = 1'b1;
                            hold  = 3;
                        end
                    end
                    @(posedge clk); #1;
                    if (hold > 0) begin
                        res_ready = 1'b0;
                        hold--;
                    end else begin
                        res_ready = 1'b1;
                    end
                end
            end
        join
        res_ready = 1'b1;
        chk("stream_count", 64'(got_n), 64'd4);
        chk("stream_timeout", 64'(prod_timeout), 64'd0);
        chk("stream_stall_seen", 64'(saw_stall), 64'd1);
        chk("stream_stable", 64'(unstable), 64'd0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("stream_res%0d", i), (i < got_q.size()) ? got_q[i] : 64'hDEAD,
                64'((i + 1) * 16 + 1));
        end

        // Reset with both stages occupied
        @(posedge clk); #1;
        res_ready = 1'b0;
        drive(6'h0D, 6'h00, 64'hA0, 64'd0, 16'h0005);
        @(posedge clk); #1;
        drive(6'h0D, 6'h00, 64'hB0, 64'd0, 16'h0005);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_res_valid", 64'(res_valid), 64'd1);
        chk("pre_rst_in_ready", 64'(in_ready), 64'd0);
        chk("pre_rst_alu_a", alu_a, 64'hB0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset     = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        chk("mid_rst_res_valid", 64'(res_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_res_data", res_data, 64'd0);
        chk("mid_rst_alu_a", alu_a, 64'd0);
        @(negedge clk);
        chk("post_rst_no_result", 64'(res_valid), 64'd0);
        issue1("post_rst_ori", 6'h0D, 6'h00, 64'h300, 64'd0, 16'h0012,
               4'd2, 64'h12, 64'h312, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Initiator side of the 64-bit EX-stage ALU.
- Accepts decoded-instruction fields plus register operands over a valid/ready handshake, and translates opcode/funct into the 4-bit ALUOp code (1=AND, 2=OR, 3=ADD, 4=SUB, 5=EQ, 6=MULT, 7=NOR).
- Drives the ALU operands from a registered issue stage, then captures out/zero/overflow into a result register with its own valid/ready handshake toward MEM.
- The ALU itself is instantiated alongside this block, not inside it.

Parameters:
- SIZE, 64, datapath width for operands and results.
- MULT_LAT, 4, cycles the issue stage holds a MULT op (used only with ALU_MULTICYCLE_MULT_EN).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  instruction fields valid.
- in_ready  output  1  block can accept this cycle.
- opcode  input  6  instruction opcode.
- funct  input  6  R-type funct field.
- rs_val  input  SIZE  first register operand.
- rt_val  input  SIZE  second register operand.
- imm  input  16  immediate field.
- alu_op  output  4  ALUOp to ALU.
- alu_a  output  SIZE  ALU operand a.
- alu_b  output  SIZE  ALU operand b.
- alu_out  input  SIZE  ALU result.
- alu_zero  input  1  ALU zero flag.
- alu_overflow  input  1  ALU overflow/carry.
- res_valid  output  1  result register valid.
- res_ready  input  1  downstream accepts result.
- res_data  output  SIZE  captured result.
- res_zero  output  1  captured zero flag.
- res_ovf  output  1  captured overflow (ADD/SUB class only).
- res_illegal  output  1  unrecognised opcode/funct.

Behaviour:
- Decode, R-type (opcode 0x00):
  - funct 0x24 → 1; 0x25 → 2; 0x2C → 3; 0x2E → 4; 0x27 → 7; 0x1C → 6.
  - b = rt_val.
- Decode, I-type:
  - 0x18 (DADDI) → 3, b = sign-extended imm.
  - 0x0C (ANDI) → 1, b = zero-extended imm.
  - 0x0D (ORI) → 2, b = zero-extended imm.
  - 0x04 (BEQ) → 5, b = rt_val.
- a = rs_val in all cases.
- Any other opcode/funct → alu_op = 0, illegal flag set; the op still flows through the pipeline so ordering is preserved.
- Stage 1 (issue register): s1_valid, alu_op, alu_a, alu_b, illegal.
  - Loads on in_valid && in_ready.
  - in_ready = !s1_valid || s1_adv.
- s1_adv = s1_valid && s1_done && (!res_valid || res_ready).
- s1_done is 1 when the feature is off.
- Stage 2 (result register): loads on s1_adv.
  - res_data = alu_out; res_zero = alu_zero.
  - res_ovf = alu_overflow only when alu_op ∈ {3,4}, else 0 (the ALU does not refresh overflow for other ops).
  - res_illegal = s1 illegal; res_data forced to 0 when illegal.
- res_valid:
  - Set on s1_adv.
  - Cleared on res_ready && !s1_adv.
  - Held when res_ready=1 and s1_adv=1 (back-to-back).
- Latency: accepted in cycle N → res_valid in N+2 (feature off). Throughput is 1 op/cycle with res_ready held high.
- Backpressure: res_valid && !res_ready stalls stage 1, which deasserts in_ready. Stage 1 and stage 2 contents stay stable while stalled.
- Reset (synchronous, active-high): all outputs reset to 0, including s1_valid, res_valid, alu_op, alu_a, alu_b, res_*. in_ready = 1 after reset. Reset mid-operation discards both stages with no partial result.
- Idle: alu_op holds its last value; alu_a and alu_b hold. Only valids gate use.

Optional Feature:
- Macro: ALU_MULTICYCLE_MULT_EN.
- When defined:
  - A counter loads MULT_LAT-1 when a MULT (alu_op 6) enters stage 1.
  - s1_done = (counter == 0); the counter decrements each cycle until 0.
  - in_ready stays low during the hold.
  - MULT latency = MULT_LAT+1 cycles; non-MULT ops are unchanged.
  - MULT_LAT=1 behaves as feature off.
- When undefined: no counter; s1_done = 1 for all ops.

Decomposition:
- Package alu_pkg:
  - ALUOp constants (ALU_AND=1 … ALU_NOR=7, ALU_NONE=0).
  - Opcode/funct constants.
  - Typedef for the 4-bit ALUOp.
- Sub-module alu_decode: combinational opcode/funct/imm → {alu_op, b_sel/extended immediate, illegal}. Shared with future decode-stage logic.

Test Plan:
- R-type DADD, rs=0x7FFF_FFFF_FFFF_FFFF, rt=1, res_ready=1 → alu_op=3, res_valid at N+2, res_data=0x8000_0000_0000_0000, res_ovf=0 (ALU carry out is 0).
- ANDI, rs=0xFFFF_FFFF_FFFF_F0F0, imm=0x8F0F → b=0x0000_0000_0000_8F0F, res_data=0x0000_0000_0000_8000, res_zero=0. DADDI with imm=0xFFFF → b=all-ones (sign-extended).
- BEQ, rs=rt=0x1234 → alu_op=5, res_data=1. Then DSUB with the same operands → res_data=0, res_zero=1.
- Opcode 0x3F → res_illegal=1, res_data=0, alu_op=0. Following op completes in order.
- Stream of 4 ORs with res_ready low for 3 cycles after the first result → in_ready drops, no result lost or duplicated, 4 results delivered in order.
- Reset asserted while stage 1 and stage 2 are both valid → next cycle res_valid=0, in_ready=1. With ALU_MULTICYCLE_MULT_EN and MULT_LAT=4, DMULT 3×5 → res_data=15 at N+5.
